nv_ram_rwsthp_param_init: RTL
=============================

// Module: nv_ram_rwsthp_param_init
// PURPOSE
//  Parametrised 1R1W RAM model for FPGA builds: registered read address, output register with bypass mux.
//  Adds over the fixed-size models: self-initialisation after reset, write-to-read forwarding,
//  a read-data valid flag and out-of-range address detection.
//  Drop-in for the nv_ram_rwsthp_<D>x<W> family inside core buffers and FIFOs.
// PARAMETERS
//  DW        36   data width
//  DEPTH     80   entries; need not be a power of 2
//  AW        7    address width, must equal $clog2(DEPTH)
//  INIT_VAL  0    DW-bit value written to every entry after reset
//  FWD_EN    1    1: same-cycle write to the pending read address forwards di to dout
// PORTS
//  clk            in   1     clock
//  rst            in   1     reset; asynchronous, active-high
//  ra             in   AW    read address
//  re             in   1     read enable; captures ra
//  ore            in   1     output register enable
//  dout           out  DW    registered read data
//  dout_vld       out  1     dout holds data from a completed read or bypass
//  wa             in   AW    write address
//  we             in   1     write enable
//  di             in   DW    write data
//  byp_sel        in   1     select dbyp instead of RAM data into dout
//  dbyp           in   DW    bypass data
//  init_busy      out  1     initialisation in progress
//  err_oor        out  1     sticky: an access used an address >= DEPTH
//  pwrbus_ram_pd  in   32    power control; functionally unused
// BEHAVIOUR
//  Reset values: dout=0, dout_vld=0, init_busy=1, err_oor=0, ra_d=0, rd_pend=0, FSM=INIT, init counter=0.
//  FSM INIT: each cycle writes INIT_VAL to M[cnt] and increments cnt.
//    After cnt==DEPTH-1 the FSM goes to READY.
//    init_busy falls exactly DEPTH cycles after reset deasserts.
//  INIT: we and re are ignored (no write, no capture, no err_oor); ore still loads dout from the bypass mux.
//  rst asserted in any state returns the FSM to INIT with cnt=0. Memory contents need not be cleared by rst itself.
//  READY is terminal until the next reset.
//  Write (READY): we && wa<DEPTH -> M[wa]<=di at the clock edge.
//  Read stage 1: re -> ra_d<=ra and rd_pend<=1.
//  Read stage 2 (next or later cycle): ore -> dout <= byp_sel ? dbyp : rdata.
//    rdata = (FWD_EN && we && wa==ra_d) ? di : M[ra_d].
//    Out-of-range ra_d gives rdata=0.
//  Latency: re@N, ore@N+1 -> dout valid at N+2.
//  A write at N to the same address as the read at N is visible in that read (write commits before stage 2).
//  dout_vld on ore: loads (rd_pend|byp_sel). rd_pend clears on ore unless re is also set that cycle.
//    Without ore, dout and dout_vld hold.
//  re and ore in the same cycle: dout loads from the old ra_d. ra_d updates to the new address.
//  err_oor sets on (we&&wa>=DEPTH) or (re&&ra>=DEPTH) in READY; it clears only on rst.
//  Simultaneous we/re to different addresses: independent. No contention X-modelling.
// STRUCTURE
//  Shared package nv_ram_pkg holds:
//    - state enum {INIT, READY}
//    - localparam helper for AW from DEPTH
//  Sub-module nv_ram_init_ctl holds the FSM and counter.
//    Outputs: init_we, init_wa, init_busy.
//  Top level muxes init_we/init_wa/INIT_VAL ahead of the user write port, plus the read pipeline and error flag.
// TESTING
//  1 Reset, then idle -> init_busy=1 for exactly 80 cycles. Reading addrs 0,40,79 then returns 0 with dout_vld=1.
//  2 we wa=5 di=36'hABCDE12 @N; re ra=5 @N; ore @N+1 -> dout=36'hABCDE12 @N+2.
//  3 re ra=9 @N; ore @N+1 with we wa=9 di=36'h5 -> dout=36'h5 (FWD_EN=1) or old M[9] (FWD_EN=0).
//  4 byp_sel=1 dbyp=36'hFFFFFFFFF ore=1, no prior re -> dout=all ones, dout_vld=1.
//    Next: ore with rd_pend=0, byp_sel=0 -> dout_vld=0.
//  5 READY; we wa=85 -> err_oor=1 next cycle, no entry modified. Reading ra=85 -> dout=0.
//  6 rst pulse at init cnt=30 -> init restarts: init_busy stays high 80 cycles after release.
//    DEPTH=17, DW=8 build passes tests 1-5.

Source files
------------

// File: rtl/nv_ram_pkg.sv
// Shared types and helpers for the parametrised nv_ram 1R1W models.
package nv_ram_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } nv_ram_state_e;

    // Address width needed to index DEPTH entries (at least one bit).
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/nv_ram_init_ctl.sv
// Post-reset initialisation sequencer: sweeps every entry once, then parks in READY.
module nv_ram_init_ctl
    import nv_ram_pkg::*;
#(
    parameter int DEPTH = 80,
    parameter int AW    = addr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          init_we,
    output logic [AW-1:0] init_wa,
    output logic          init_busy
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    nv_ram_state_e state;
    logic [AW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= INIT;
            cnt       <= '0;
            init_busy <= 1'b1;
        end else begin
            case (state)
                INIT: begin
                    if (cnt == LAST) begin
                        state     <= READY;
                        init_busy <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= READY;
                    init_busy <= 1'b0;
                end
            endcase
        end
    end

    // init_busy is high exactly while the sweep writes M[cnt].
    assign init_we = init_busy;
    assign init_wa = cnt;

endmodule

// File: rtl/nv_ram_rwsthp_param_init.sv
// Parametrised 1R1W RAM: self-initialising, registered read address, output register with bypass.
module nv_ram_rwsthp_param_init #(
    parameter int                DW       = 36,
    parameter int                DEPTH    = 80,
    parameter int                AW       = 7,
    parameter logic [DW-1:0]     INIT_VAL = '0,
    parameter bit                FWD_EN   = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ra,
    input  logic          re,
    input  logic          ore,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    input  logic [AW-1:0] wa,
    input  logic          we,
    input  logic [DW-1:0] di,
    input  logic          byp_sel,
    input  logic [DW-1:0] dbyp,
    output logic          init_busy,
    output logic          err_oor,
    input  logic [31:0]   pwrbus_ram_pd
);

    localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic          init_we;
    logic [AW-1:0] init_wa;
    logic          ready;
    logic          wa_ok, ra_ok, rd_ok;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] ra_d;
    logic          rd_pend;
    logic          fwd_hit;
    logic [DW-1:0] rdata;
    logic          unused_pwr;

    assign unused_pwr = ^pwrbus_ram_pd;

    nv_ram_init_ctl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_init_ctl (
        .clk       (clk),
        .rst       (rst),
        .init_we   (init_we),
        .init_wa   (init_wa),
        .init_busy (init_busy)
    );

    assign ready = ~init_busy;
    assign wa_ok = {1'b0, wa}   < DEPTH_X;
    assign ra_ok = {1'b0, ra}   < DEPTH_X;
    assign rd_ok = {1'b0, ra_d} < DEPTH_X;

    // The init sweep owns the write port until READY; user writes are dropped meanwhile.
    assign wr_en   = init_we | (ready & we & wa_ok);
    assign wr_addr = init_we ? init_wa  : wa;
    assign wr_data = init_we ? INIT_VAL : di;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign fwd_hit = FWD_EN && ready && we && wa_ok && (wa == ra_d);

    always_comb begin
        rdata = '0;
        if (fwd_hit) begin
            rdata = di;
        end else if (rd_ok) begin
            rdata = mem[ra_d];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra_d     <= '0;
            rd_pend  <= 1'b0;
            dout     <= '0;
            dout_vld <= 1'b0;
            err_oor  <= 1'b0;
        end else begin
            if (ore) begin
                dout     <= byp_sel ? dbyp : rdata;
                dout_vld <= rd_pend | byp_sel;
            end
            // A new capture in the same cycle as ore keeps the read pending.
            if (ready && re) begin
                ra_d    <= ra;
                rd_pend <= 1'b1;
            end else if (ore) begin
                rd_pend <= 1'b0;
            end
            if (ready && ((we && !wa_ok) || (re && !ra_ok))) begin
                err_oor <= 1'b1;
            end
        end
    end

endmodule
